dm_port_arbiter: RTL

- Shares the single-port data memory between two requesters: port 0 is the CPU MEM stage, port 1 is the DMA/debug master.
- Decodes each request's access op into a word address, lane-aligned write data and a byte enable.
- Issues the access on a req/ack memory handshake, then returns sign- or zero-extended load data with a one-cycle ack.
- Detects misaligned accesses and memory timeouts and reports both as errors.

---
 rtl/dm_port_arbiter.sv | 256 +++++++++++++++++++++++++
 1 files changed

// File: rtl/dm_port_arbiter.sv
// Two-port arbiter in front of a single-port data memory.
// Port 0 is the CPU MEM stage, port 1 is the DMA/debug master. A request is
// decoded into a word address, lane-aligned write data and byte enables,
// issued on a req/ack memory handshake, and completed with a one-cycle ack.
// Load data is extracted from the returned word and sign/zero extended.
// Misaligned accesses never reach memory; a memory that stays silent for
// TIMEOUT cycles is abandoned. Both cases complete with err=1.
//
// state  | meaning
// IDLE   | sample requests, arbitrate, latch and decode the winner
// ISSUE  | m_req held high, waiting for m_ack or the timeout
// DONE   | one-cycle ack/err/rdata pulse to the granted port
module dm_port_arbiter #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req0,
  input  logic        i_req1,
  input  logic [3:0]  i_op0,
  input  logic [3:0]  i_op1,
  input  logic [31:0] i_addr0,
  input  logic [31:0] i_addr1,
  input  logic [31:0] i_wdata0,
  input  logic [31:0] i_wdata1,
  output logic        o_ack0,
  output logic        o_ack1,
  output logic        o_err0,
  output logic        o_err1,
  output logic [31:0] o_rdata0,
  output logic [31:0] o_rdata1,
  output logic        o_m_req,
  output logic [31:0] o_m_addr,
  output logic        o_m_we,
  output logic [3:0]  o_m_byteen,
  output logic [31:0] o_m_wdata,
  input  logic        i_m_ack,
  input  logic [31:0] i_m_rdata
);

  localparam logic [3:0] OP_NONE = 4'd0;
  localparam logic [3:0] OP_SW   = 4'd1;
  localparam logic [3:0] OP_SH   = 4'd2;
  localparam logic [3:0] OP_SB   = 4'd3;
  localparam logic [3:0] OP_LW   = 4'd4;
  localparam logic [3:0] OP_LH   = 4'd5;
  localparam logic [3:0] OP_LHU  = 4'd6;
  localparam logic [3:0] OP_LB   = 4'd7;
  localparam logic [3:0] OP_LBU  = 4'd8;

  // Last ISSUE cycle before giving up on the memory.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_last;      // port granted most recently
  logic             r_gnt;       // port owning the current transaction
  logic [3:0]       r_op;
  logic [1:0]       r_off;       // byte offset within the word
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_ack;
  logic [1:0]       r_err;
  logic [31:0]      r_rdata0;
  logic [31:0]      r_rdata1;
  logic             r_m_req;
  logic [31:0]      r_m_addr;
  logic             r_m_we;
  logic [3:0]       r_m_byteen;
  logic [31:0]      r_m_wdata;

  logic             w_any;
  logic             w_gnt;
  logic [3:0]       w_op;
  logic [31:0]      w_addr;
  logic [31:0]      w_wdata;
  logic [31:0]      w_load;

  // ops 9..15 behave exactly like op 0
  function automatic logic f_is_none(input logic [3:0] op);
    return (op == OP_NONE) || (op > OP_LBU);
  endfunction

  function automatic logic f_is_store(input logic [3:0] op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

  function automatic logic f_misaligned(input logic [3:0] op, input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    case (op)
      OP_SW, OP_LW:          bad = (off != 2'b00);
      OP_SH, OP_LH, OP_LHU:  bad = off[0];
      default:               bad = 1'b0;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] f_byteen(input logic [3:0] op, input logic [1:0] off);
    logic [3:0] be;
    be = 4'b0000;
    case (op)
      OP_SW:   be = 4'b1111;
      OP_SH:   be = off[1] ? 4'b1100 : 4'b0011;
      OP_SB:   be = 4'b0001 << off;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicating the datum puts it in every lane; the byte enables pick the
  // one that actually gets written.
  function automatic logic [31:0] f_lanes(input logic [3:0] op, input logic [31:0] d);
    logic [31:0] w;
    w = 32'h0;
    case (op)
      OP_SW:   w = d;
      OP_SH:   w = {2{d[15:0]}};
      OP_SB:   w = {4{d[7:0]}};
      default: w = 32'h0;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] f_extract(input logic [3:0] op, input logic [1:0] off,
                                            input logic [31:0] word);
    logic [31:0] shifted;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    shifted = word >> {off, 3'b000};
    b       = shifted[7:0];
    h       = off[1] ? word[31:16] : word[15:0];
    r       = 32'h0;
    case (op)
      OP_LW:   r = word;
      OP_LH:   r = {{16{h[15]}}, h};
      OP_LHU:  r = {16'h0, h};
      OP_LB:   r = {{24{b[7]}}, b};
      OP_LBU:  r = {24'h0, b};
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  // Round-robin pick: on a tie the port not granted last time wins.
  always_comb begin
    w_any   = i_req0 | i_req1;
    w_gnt   = (i_req0 && i_req1) ? ~r_last : i_req1;
    w_op    = w_gnt ? i_op1    : i_op0;
    w_addr  = w_gnt ? i_addr1  : i_addr0;
    w_wdata = w_gnt ? i_wdata1 : i_wdata0;
  end

  // Load data as it will be returned if memory acks this cycle.
  always_comb begin
    w_load = f_extract(r_op, r_off, i_m_rdata);
  end

  // Arbitration / handshake FSM with registered outputs.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_last     <= 1'b1;
      r_gnt      <= 1'b0;
      r_op       <= OP_NONE;
      r_off      <= 2'b00;
      r_cnt      <= '0;
      r_ack      <= 2'b00;
      r_err      <= 2'b00;
      r_rdata0   <= 32'h0;
      r_rdata1   <= 32'h0;
      r_m_req    <= 1'b0;
      r_m_addr   <= 32'h0;
      r_m_we     <= 1'b0;
      r_m_byteen <= 4'b0000;
      r_m_wdata  <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_gnt  <= w_gnt;
            r_last <= w_gnt;
            r_op   <= w_op;
            r_off  <= w_addr[1:0];
            r_cnt  <= '0;
            if (f_is_none(w_op) || f_misaligned(w_op, w_addr[1:0])) begin
              // completes without touching memory
              r_ack[w_gnt] <= 1'b1;
              r_err[w_gnt] <= ~f_is_none(w_op);
              r_state      <= S_DONE;
            end else begin
              r_m_req    <= 1'b1;
              r_m_addr   <= {w_addr[31:2], 2'b00};
              r_m_we     <= f_is_store(w_op);
              r_m_byteen <= f_byteen(w_op, w_addr[1:0]);
              r_m_wdata  <= f_lanes(w_op, w_wdata);
              r_state    <= S_ISSUE;
            end
          end
        end

        S_ISSUE: begin
          if (i_m_ack || (r_cnt == CNT_LAST)) begin
            // an ack on the final cycle still counts as success
            r_ack[r_gnt] <= 1'b1;
            r_err[r_gnt] <= ~i_m_ack;
            if (i_m_ack) begin
              if (r_gnt) r_rdata1 <= w_load;
              else       r_rdata0 <= w_load;
            end
            r_m_req    <= 1'b0;
            r_m_addr   <= 32'h0;
            r_m_we     <= 1'b0;
            r_m_byteen <= 4'b0000;
            r_m_wdata  <= 32'h0;
            r_state    <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_DONE: begin
          r_ack    <= 2'b00;
          r_err    <= 2'b00;
          r_rdata0 <= 32'h0;
          r_rdata1 <= 32'h0;
          r_cnt    <= '0;
          r_state  <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_ack0     = r_ack[0];
  assign o_ack1     = r_ack[1];
  assign o_err0     = r_err[0];
  assign o_err1     = r_err[1];
  assign o_rdata0   = r_rdata0;
  assign o_rdata1   = r_rdata1;
  assign o_m_req    = r_m_req;
  assign o_m_addr   = r_m_addr;
  assign o_m_we     = r_m_we;
  assign o_m_byteen = r_m_byteen;
  assign o_m_wdata  = r_m_wdata;

endmodule
